// File: rtl/stepmotor_ctrl.sv
// -----------------------------------------------------------------------------
// stepmotor_ctrl
//   Unipolar 4-coil stepper-motor controller. It accepts one move command
//   through a valid/ready handshake and runs exactly that many steps at a
//   fixed step period, in full-step (two-coil) or half-step mode. When the
//   move is finished it pulses o_done. After the first step the coil pattern
//   is held in IDLE, so the motor keeps its holding torque.
//
// Optional feature (compile-time macro STEP_POSITION_EN):
//   When defined, this adds a signed, wrapping position counter (o_position)
//   and a synchronous clear input (i_pos_clear).
//
// Parameters:
//   CNT_W   width of the step-period timer and of i_cmd_period
//   MOVE_W  width of i_cmd_steps and o_steps_left
//   POS_W   width of o_position (used only with STEP_POSITION_EN)
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_cmd_valid    move command present
//   o_cmd_ready    controller can accept a command (high only in IDLE)
//   i_cmd_steps    number of steps to move
//   i_cmd_dir      1 = forward (phase index increments), 0 = reverse
//   i_cmd_half     1 = half-step (8 phases), 0 = full-step (4 phases)
//   i_cmd_period   clocks per step; 0 is treated as 1
//   i_abort        stop the current move at the next clock edge
//   o_step_drive   coil drive pattern
//   o_step_pulse   one-cycle strobe on every step taken
//   o_busy         move in progress
//   o_done         one-cycle pulse at the end of a move
//   o_steps_left   steps remaining in the current or last move
//   i_pos_clear    (STEP_POSITION_EN) clear the position counter
//   o_position     (STEP_POSITION_EN) signed step position
// -----------------------------------------------------------------------------
module stepmotor_ctrl #(
    parameter int CNT_W  = 32,
    parameter int MOVE_W = 16,
    parameter int POS_W  = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [MOVE_W-1:0]       i_cmd_steps,
    input  logic                    i_cmd_dir,
    input  logic                    i_cmd_half,
    input  logic [CNT_W-1:0]        i_cmd_period,
    input  logic                    i_abort,
    output logic [3:0]              o_step_drive,
    output logic                    o_step_pulse,
    output logic                    o_busy,
    output logic                    o_done,
`ifdef STEP_POSITION_EN
    input  logic                    i_pos_clear,
    output logic signed [POS_W-1:0] o_position,
`endif
    output logic [MOVE_W-1:0]       o_steps_left
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MOVE_W-1:0] MOVE_ONE = {{(MOVE_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [2:0]          r_phase;
    logic [CNT_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_period;
    logic                r_dir;
    logic                r_half;
    logic [MOVE_W-1:0]   r_steps_left;
    logic [3:0]          r_drive;
    logic                r_pulse;
    logic                r_done;
    logic                r_busy;
    logic                r_ready;

    logic                w_tick;
    logic                w_step;
    logic [2:0]          w_next_phase;

    // Half-step sequence. Odd indices energise two coils; even indices energise one.
    function automatic logic [3:0] phase_pattern(input logic [2:0] phase);
        case (phase)
            3'd0:    phase_pattern = 4'b0001;
            3'd1:    phase_pattern = 4'b0011;
            3'd2:    phase_pattern = 4'b0010;
            3'd3:    phase_pattern = 4'b0110;
            3'd4:    phase_pattern = 4'b0100;
            3'd5:    phase_pattern = 4'b1100;
            3'd6:    phase_pattern = 4'b1000;
            default: phase_pattern = 4'b1001;
        endcase
    endfunction

    // In full-step mode the controller moves by 2 from an odd index. From an
    // even index it moves by 1, so it always lands on a two-coil (odd) phase.
    function automatic logic [2:0] advance(input logic [2:0] phase,
                                           input logic       dir,
                                           input logic       half);
        logic [2:0] inc;
        inc = (half || !phase[0]) ? 3'd1 : 3'd2;
        advance = dir ? (phase + inc) : (phase - inc);
    endfunction

    assign w_tick       = (r_state == RUN) && (r_timer == r_period - CNT_ONE);
    // An abort takes priority over a step tick that falls on the same edge.
    assign w_step       = w_tick && !i_abort;
    assign w_next_phase = advance(r_phase, r_dir, r_half);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_phase      <= 3'd0;
            r_timer      <= '0;
            r_period     <= CNT_ONE;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_steps_left <= '0;
            r_drive      <= 4'b0000;
            r_pulse      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            // NOTE: strobes default low every cycle; the branches below only raise them.
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_steps_left <= i_cmd_steps;
                        r_dir        <= i_cmd_dir;
                        r_half       <= i_cmd_half;
                        r_period     <= (i_cmd_period == '0) ? CNT_ONE : i_cmd_period;
                        r_timer      <= '0;
                        if (i_cmd_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_timer      <= '0;
                        r_phase      <= w_next_phase;
                        r_drive      <= phase_pattern(w_next_phase);
                        r_pulse      <= 1'b1;
                        r_steps_left <= r_steps_left - MOVE_ONE;
                        if (r_steps_left == MOVE_ONE) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef STEP_POSITION_EN
    localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic signed [POS_W-1:0] r_position;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_pos_clear) begin
            r_position <= '0;
        end else if (w_step) begin
            r_position <= r_dir ? (r_position + POS_ONE) : (r_position - POS_ONE);
        end
    end

    assign o_position = r_position;
`endif

    assign o_cmd_ready  = r_ready;
    assign o_step_drive = r_drive;
    assign o_step_pulse = r_pulse;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_steps_left = r_steps_left;

endmodule

// File: tb/tb_stepmotor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepmotor_ctrl
//   Directed testbench for stepmotor_ctrl with hand-computed expected values.
//   Inputs are driven and outputs are sampled 1 ns after each rising edge.
//   Cycle index c counts rising edges after the accepting edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stepmotor_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic        cmd_half = 1'b0;
    logic [31:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic [3:0]  step_drive;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic [15:0] steps_left;
`ifdef STEP_POSITION_EN
    logic        pos_clear = 1'b0;
    logic signed [23:0] position;
`endif

    int checks   = 0;
    int failures = 0;

    stepmotor_ctrl #(.CNT_W(32), .MOVE_W(16), .POS_W(24)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_steps  (cmd_steps),
        .i_cmd_dir    (cmd_dir),
        .i_cmd_half   (cmd_half),
        .i_cmd_period (cmd_period),
        .i_abort      (abort),
        .o_step_drive (step_drive),
        .o_step_pulse (step_pulse),
        .o_busy       (busy),
        .o_done       (done),
`ifdef STEP_POSITION_EN
        .i_pos_clear  (pos_clear),
        .o_position   (position),
`endif
        .o_steps_left (steps_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one command for exactly one edge; returns 1 ns after the accepting edge.
    task automatic issue_cmd(input logic [15:0] s, input logic d, input logic h,
                             input logic [31:0] p);
        cmd_steps  = s;
        cmd_dir    = d;
        cmd_half   = h;
        cmd_period = p;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (10) tick();
        checks++; if (step_drive !== 4'b0000) begin failures++; $display("FAIL reset_drive got=%b exp=0000", step_drive); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (step_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", step_pulse); end
        checks++; if (steps_left !== 16'd0) begin failures++; $display("FAIL reset_steps_left got=%0d exp=0", steps_left); end
    endtask

    task automatic test_half_forward();
        logic [3:0] seq [4];
        logic       exp_pulse;
        seq[0] = 4'b0011; seq[1] = 4'b0010; seq[2] = 4'b0110; seq[3] = 4'b0100;
        issue_cmd(16'd4, 1'b1, 1'b1, 32'd5);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL half_busy_after_accept got=%b exp=1", busy); end
        for (int c = 1; c <= 22; c++) begin
            tick();
            exp_pulse = (c % 5 == 0) && (c <= 20);
            checks++; if (step_pulse !== exp_pulse) begin failures++; $display("FAIL half_pulse c=%0d got=%b exp=%b", c, step_pulse, exp_pulse); end
            if (exp_pulse) begin
                checks++; if (step_drive !== seq[c/5-1]) begin failures++; $display("FAIL half_drive c=%0d got=%b exp=%b", c, step_drive, seq[c/5-1]); end
            end
            checks++; if (busy !== (c < 20)) begin failures++; $display("FAIL half_busy c=%0d got=%b", c, busy); end
            checks++; if (done !== (c == 20)) begin failures++; $display("FAIL half_done c=%0d got=%b", c, done); end
        end
        checks++; if (step_drive !== 4'b0100) begin failures++; $display("FAIL half_hold got=%b exp=0100", step_drive); end
        checks++; if (steps_left !== 16'd0) begin failures++; $display("FAIL half_steps_left got=%0d exp=0", steps_left); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL half_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_full_reverse();
        logic [3:0] seq [3];
        logic       exp_pulse;
        seq[0] = 4'b1001; seq[1] = 4'b1100; seq[2] = 4'b0110;
        apply_reset();
        issue_cmd(16'd3, 1'b0, 1'b0, 32'd2);
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_pulse = (c % 2 == 0) && (c <= 6);
            checks++; if (step_pulse !== exp_pulse) begin failures++; $display("FAIL full_pulse c=%0d got=%b exp=%b", c, step_pulse, exp_pulse); end
            if (exp_pulse) begin
                checks++; if (step_drive !== seq[c/2-1]) begin failures++; $display("FAIL full_drive c=%0d got=%b exp=%b", c, step_drive, seq[c/2-1]); end
            end
            checks++; if (done !== (c == 6)) begin failures++; $display("FAIL full_done c=%0d got=%b", c, done); end
        end
        checks++; if (step_drive !== 4'b0110) begin failures++; $display("FAIL full_hold got=%b exp=0110", step_drive); end
    endtask

    task automatic test_zero_steps();
        issue_cmd(16'd0, 1'b1, 1'b1, 32'd5);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
        checks++; if (steps_left !== 16'd0) begin failures++; $display("FAIL zero_steps_left got=%0d exp=0", steps_left); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0 || step_pulse !== 1'b0) begin
                failures++; $display("FAIL zero_quiet c=%0d done=%b busy=%b pulse=%b exp=000", c, done, busy, step_pulse);
            end
        end
        checks++; if (step_drive !== 4'b0110) begin failures++; $display("FAIL zero_drive got=%b exp=0110", step_drive); end
    endtask

    // Period 0 behaves as period 1: one step per clock. Phase 3 -> 4 -> 5.
    task automatic test_period_zero();
        issue_cmd(16'd2, 1'b1, 1'b1, 32'd0);
        tick();
        checks++; if (step_pulse !== 1'b1 || step_drive !== 4'b0100) begin failures++; $display("FAIL p0_step1 pulse=%b drive=%b exp=1/0100", step_pulse, step_drive); end
        tick();
        checks++; if (step_pulse !== 1'b1 || step_drive !== 4'b1100) begin failures++; $display("FAIL p0_step2 pulse=%b drive=%b exp=1/1100", step_pulse, step_drive); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL p0_done got=%b exp=1", done); end
        tick();
        checks++; if (step_pulse !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL p0_after pulse=%b busy=%b exp=0/0", step_pulse, busy); end
    endtask

    task automatic test_abort();
        logic exp_pulse;
        apply_reset();
        issue_cmd(16'd10, 1'b1, 1'b1, 32'd3);
        for (int c = 1; c <= 11; c++) begin
            tick();
            exp_pulse = (c % 3 == 0);
            checks++; if (step_pulse !== exp_pulse) begin failures++; $display("FAIL abort_pulse c=%0d got=%b exp=%b", c, step_pulse, exp_pulse); end
        end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL abort_ready_busy got=%b exp=0", cmd_ready); end
        // Edge 12 is the 4th step tick; abort and an ignored command coincide with it.
        abort      = 1'b1;
        cmd_steps  = 16'd5;
        cmd_valid  = 1'b1;
        tick();
        abort      = 1'b0;
        cmd_valid  = 1'b0;
        checks++; if (step_pulse !== 1'b0) begin failures++; $display("FAIL abort_no_step got=%b exp=0", step_pulse); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (steps_left !== 16'd7) begin failures++; $display("FAIL abort_steps_left got=%0d exp=7", steps_left); end
        checks++; if (step_drive !== 4'b0110) begin failures++; $display("FAIL abort_drive got=%b exp=0110", step_drive); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || steps_left !== 16'd7) begin
            failures++; $display("FAIL abort_after done=%b busy=%b steps_left=%0d exp=0/0/7", done, busy, steps_left);
        end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
    endtask

    // An abort with no move running has no effect. With a coincident command, the command wins.
    task automatic test_idle_abort();
        abort = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_abort done=%b busy=%b exp=0/0", done, busy); end
        issue_cmd(16'd1, 1'b1, 1'b1, 32'd1);
        abort = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL idle_abort_accept busy=%b exp=1", busy); end
        tick();
        checks++; if (step_pulse !== 1'b1 || done !== 1'b1 || step_drive !== 4'b0100) begin
            failures++; $display("FAIL idle_abort_step pulse=%b done=%b drive=%b exp=1/1/0100", step_pulse, done, step_drive);
        end
    endtask

    task automatic test_reset_mid_move();
        issue_cmd(16'd5, 1'b1, 1'b1, 32'd2);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (step_drive !== 4'b0000) begin failures++; $display("FAIL midrst_drive got=%b exp=0000", step_drive); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_state busy=%b ready=%b exp=0/1", busy, cmd_ready); end
        checks++; if (steps_left !== 16'd0) begin failures++; $display("FAIL midrst_steps_left got=%0d exp=0", steps_left); end
        tick();
        checks++; if (step_pulse !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_quiet pulse=%b done=%b exp=0/0", step_pulse, done); end
    endtask

`ifdef STEP_POSITION_EN
    task automatic test_position();
        apply_reset();
        checks++; if (position !== 24'sd0) begin failures++; $display("FAIL pos_reset got=%0d exp=0", position); end
        issue_cmd(16'd6, 1'b1, 1'b1, 32'd1);
        repeat (6) tick();
        checks++; if (position !== 24'sd6) begin failures++; $display("FAIL pos_fwd6 got=%0d exp=6", position); end
        tick();
        issue_cmd(16'd2, 1'b0, 1'b1, 32'd1);
        repeat (2) tick();
        checks++; if (position !== 24'sd4) begin failures++; $display("FAIL pos_rev2 got=%0d exp=4", position); end
        tick();
        issue_cmd(16'd2, 1'b1, 1'b1, 32'd2);
        tick();
        tick();
        checks++; if (position !== 24'sd5) begin failures++; $display("FAIL pos_step got=%0d exp=5", position); end
        tick();
        pos_clear = 1'b1;
        tick();
        pos_clear = 1'b0;
        checks++; if (step_pulse !== 1'b1 || position !== 24'sd0) begin failures++; $display("FAIL pos_clear pulse=%b pos=%0d exp=1/0", step_pulse, position); end
        tick();
        issue_cmd(16'd1, 1'b0, 1'b1, 32'd1);
        tick();
        checks++; if (position !== 24'hFFFFFF) begin failures++; $display("FAIL pos_wrap got=%h exp=ffffff", position); end
    endtask
`endif

    initial begin
        test_reset();
        test_half_forward();
        test_full_reverse();
        test_zero_steps();
        test_period_zero();
        test_abort();
        test_idle_abort();
        test_reset_mid_move();
`ifdef STEP_POSITION_EN
        test_position();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
